// File: rtl/noise_injector_if.sv
// -----------------------------------------------------------------------------
// noise_injector_if
// Purpose : groups the sample-stream, control and BRAM-write signals of the
//           noise injector into one bundle.
// Signals : start     - single-cycle frame start request
//           switches  - [3] noise enable, [2:0] amplitude k
//           in_valid  - upstream sample valid
//           in_data   - clean sample (unsigned offset-binary)
//           in_ready  - block accepts a sample this cycle
//           bram_we   - BRAM write strobe
//           bram_addr - BRAM write address
//           bram_wdata- distorted sample to store
//           busy/done - frame running / frame complete
//           sat_count - clamped samples in the current frame
// Modports: slave  - the noise injector itself
//           master - whatever drives the stream and consumes the writes
// -----------------------------------------------------------------------------
interface noise_injector_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [3:0]        switches;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sat_count;

  modport slave (
    input  start, switches, in_valid, in_data,
    output in_ready, bram_we, bram_addr, bram_wdata, busy, done, sat_count
  );

  modport master (
    output start, switches, in_valid, in_data,
    input  in_ready, bram_we, bram_addr, bram_wdata, busy, done, sat_count
  );
endinterface

// File: rtl/noise_injector.sv
// -----------------------------------------------------------------------------
// noise_injector
// Purpose : takes one frame of DEPTH audio samples, adds LFSR-derived noise of
//           selectable amplitude, saturates to the sample range and writes each
//           result to a BRAM one cycle after the sample is accepted.
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - noise_injector_if.slave (stream in, BRAM write out, status)
// -----------------------------------------------------------------------------
module noise_injector #(
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 1024,
  parameter int          ADDR_W = 10,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  noise_injector_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [ADDR_W:0]   sat_q, sat_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              accept;
  logic              last_sample;
  logic [15:0]       lfsr_step;
  logic [2:0]        shamt;
  logic signed [7:0] noise;
  logic [DATA_W+1:0] noise_ext;
  logic [DATA_W+1:0] sum;
  logic              sum_neg;
  logic              sum_over;
  logic [DATA_W-1:0] clamped;

  assign accept      = (state_q == S_RUN) && bus.in_valid;
  assign last_sample = (idx_q == ADDR_W'(DEPTH - 1));

  // Galois form, right shift: feedback bit is the outgoing LSB, folded into
  // the tap positions 16,14,13,11 -> mask 0xB400.
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Amplitude k keeps the top k+1 bits of the signed byte.
  assign shamt = 3'd7 - bus.switches[2:0];
  assign noise = bus.switches[3] ? ($signed(lfsr_q[7:0]) >>> shamt) : 8'sd0;

  // Two guard bits: the top bit flags an underflow, the next an overflow.
  assign noise_ext = {{(DATA_W-6){noise[7]}}, noise};
  assign sum       = {2'b00, bus.in_data} + noise_ext;
  assign sum_neg   = sum[DATA_W+1];
  assign sum_over  = !sum_neg && sum[DATA_W];

  always_comb begin
    clamped = sum[DATA_W-1:0];
    if (sum_neg)       clamped = '0;
    else if (sum_over) clamped = '1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    sat_d   = sat_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          lfsr_d  = SEED;
          sat_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = clamped;
          lfsr_d  = lfsr_step;
          if (sum_neg || sum_over) sat_d = sat_q + (ADDR_W+1)'(1);
          // The index stays on DEPTH-1 at frame end so it never wraps.
          if (last_sample) state_d = S_DONE;
          else             idx_d   = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lfsr_q  <= SEED;
      sat_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      sat_q   <= sat_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready   = (state_q == S_RUN);
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.sat_count  = sat_q;

endmodule

// File: tb/tb_noise_injector.sv
// -----------------------------------------------------------------------------
// tb_noise_injector
// Drives frames into noise_injector, predicts every BRAM write with an
// arithmetic reference model, and checks the writes from a separate monitor.
// -----------------------------------------------------------------------------
module tb_noise_injector;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int SEED   = 'hACE1;

  typedef struct {
    int addr;
    int data;
    int sat;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  // reference model state
  bit m_run;
  bit m_done;
  int m_idx;
  int m_lfsr;
  int m_sat;

  noise_injector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  noise_injector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Galois LFSR step for x^16+x^14+x^13+x^11, shifting right.
  function automatic int ref_next(input int lf);
    return (lf % 2 == 1) ? ((lf / 2) ^ 'hB400) : (lf / 2);
  endfunction

  // Low byte as a signed value divided by 2^(7-k), rounded toward -infinity.
  function automatic int ref_noise(input int lf, input logic [3:0] sw);
    int v, d, k;
    if (!sw[3]) return 0;
    v = lf % 256;
    if (v >= 128) v = v - 256;
    k = int'(sw[2:0]);
    d = 1 << (7 - k);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && bus.bram_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(bus.bram_addr), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_addr",  int'(bus.bram_addr),  e.addr);
        chk("write_data",  int'(bus.bram_wdata), e.data);
        chk("write_sat",   int'(bus.sat_count),  e.sat);
      end
    end
  end

  // One clock cycle of stimulus; the model predicts what it does.
  task automatic do_cycle(input bit st, input bit v, input int d, input logic [3:0] sw);
    bus.start    = st;
    bus.in_valid = v;
    bus.in_data  = 8'(d);
    bus.switches = sw;
    if (m_run && v) begin
      exp_t e;
      int s;
      s = (d % 256) + ref_noise(m_lfsr, sw);
      if (s < 0) begin s = 0; m_sat++; end
      else if (s > 255) begin s = 255; m_sat++; end
      e.addr = m_idx;
      e.data = s;
      e.sat  = m_sat;
      exp_q.push_back(e);
      m_lfsr = ref_next(m_lfsr);
      m_idx++;
      if (m_idx == DEPTH) begin
        m_run  = 0;
        m_done = 1;
      end
    end else if (!m_run && st) begin
      m_run  = 1;
      m_done = 0;
      m_idx  = 0;
      m_lfsr = SEED;
      m_sat  = 0;
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk("busy",      int'(bus.busy),      int'(m_run));
    chk("done",      int'(bus.done),      int'(m_done));
    chk("in_ready",  int'(bus.in_ready),  int'(m_run));
    chk("sat_count", int'(bus.sat_count), m_sat);
  endtask

  task automatic do_reset();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    m_run  = 0;
    m_done = 0;
    m_idx  = 0;
    m_sat  = 0;
    exp_q.delete();
    #1;
    chk("rst_in_ready", int'(bus.in_ready),   0);
    chk("rst_we",       int'(bus.bram_we),    0);
    chk("rst_addr",     int'(bus.bram_addr),  0);
    chk("rst_wdata",    int'(bus.bram_wdata), 0);
    chk("rst_busy",     int'(bus.busy),       0);
    chk("rst_done",     int'(bus.done),       0);
    chk("rst_sat",      int'(bus.sat_count),  0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one frame. first >= 0 forces the first sample; exp_first >= 0 checks
  // the first write against a hand-computed value; abort_at >= 0 resets once
  // that many samples have been accepted.
  task automatic frame(input int first, input logic [3:0] sw, input bit rnd,
                       input int abort_at, input int exp_first, input int exp_sat);
    int n, guard, d;
    bit v, st;
    logic [3:0] swn;
    n = 0;
    guard = 0;
    do_cycle(1'b1, 1'b0, 0, sw);
    while (m_run) begin
      if (abort_at >= 0 && m_idx == abort_at) begin
        do_reset();
        return;
      end
      v   = (n == 0) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      d   = (n == 0 && first >= 0) ? first : (rnd ? int'($urandom_range(0, 255)) : m_idx % 256);
      st  = rnd && ($urandom_range(0, 31) == 0);
      swn = (rnd && n > 0) ? {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))} : sw;
      do_cycle(st, v, d, swn);
      if (n == 0 && exp_first >= 0) begin
        chk("first_we",    int'(bus.bram_we),    1);
        chk("first_wdata", int'(bus.bram_wdata), exp_first);
        chk("first_sat",   int'(bus.sat_count),  exp_sat);
      end
      if (v) n++;
      guard++;
      if (guard > 5000) begin
        chk("frame_timeout", guard, 0);
        break;
      end
    end
    // The final write is visible in the first DONE cycle.
    chk("final_we",   int'(bus.bram_we),   1);
    chk("final_addr", int'(bus.bram_addr), DEPTH - 1);
    chk("final_done", int'(bus.done),      1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.start    = 1'b0;
    bus.switches = 4'b0000;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    do_reset();

    // Clean pass-through ramp, no saturation.
    frame(-1, 4'b0000, 1'b0, -1, -1, 0);
    chk("ramp_sat", int'(bus.sat_count), 0);

    // Samples offered in DONE must be ignored, index held.
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, i * 37, 4'b1111);
    chk("done_addr_held", int'(bus.bram_addr), DEPTH - 1);
    chk("done_no_we",     int'(bus.bram_we),   0);

    // Full-amplitude noise from SEED low byte 0xE1 (-31).
    frame(200, 4'b1111, 1'b0, -1, 169, 0);
    frame(20,  4'b1111, 1'b0, -1, 0,   1);
    // k=3: -31 >>> 4 = -2.
    frame(100, 4'b1011, 1'b0, -1, 98,  0);

    // Random valid/switches/start, abort at index 500, then a full frame.
    frame(-1, 4'b1111, 1'b1, 500, -1, 0);
    frame(200, 4'b1111, 1'b1, -1, 169, 0);

    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 0, 4'b0000);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/noise_injector.md
NOISE_INJECTOR -- requirements
Module: noise_injector

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits; samples are unsigned offset-binary.
REQ-002 Parameter DEPTH, default 1024: number of samples per frame.
REQ-003 Parameter ADDR_W, default 10: BRAM address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Parameter SEED, default 16'hACE1: LFSR load value; SHALL be non-zero.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: single-cycle request to begin a frame.
REQ-008 Port switches, input, 4 bits: bit 3 is noise enable; bits 2:0 are amplitude k.
REQ-009 Port in_valid, input, 1 bit: upstream sample valid.
REQ-010 Port in_data, input, DATA_W bits: clean audio sample.
REQ-011 Port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-012 Port bram_we, output, 1 bit: BRAM write strobe.
REQ-013 Port bram_addr, output, ADDR_W bits: BRAM write address.
REQ-014 Port bram_wdata, output, DATA_W bits: distorted sample to store.
REQ-015 Port busy, output, 1 bit: high in state RUN.
REQ-016 Port done, output, 1 bit: high in state DONE.
REQ-017 Port sat_count, output, ADDR_W+1 bits: number of clamped samples in the current frame.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE or DONE with start=1 -> RUN: write index := 0, LFSR := SEED, sat_count := 0.
- start in RUN SHALL be ignored.
REQ-019 in_ready SHALL equal 1 only in RUN; a sample is accepted when in_valid && in_ready.
REQ-020 The LFSR SHALL be a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11, right-shifting; it SHALL advance exactly once per accepted sample and otherwise hold.
- Each sample uses the LFSR value before its advance, so the first sample of a frame uses SEED.
REQ-021 Noise n SHALL be computed as follows:
- switches[3]=1: n = signed(lfsr[7:0]) arithmetically shifted right by (7-k).
- switches[3]=0: n = 0.
- switches SHALL be sampled in the acceptance cycle.
REQ-022 The sum s = in_data + sign-extended n SHALL be evaluated in DATA_W+2-bit signed arithmetic.
- s < 0 writes 0; s > 2**DATA_W-1 writes 2**DATA_W-1; otherwise s is written.
- Each clamp increments sat_count by 1.
REQ-023 Write latency SHALL be one cycle.
- The cycle after an acceptance: bram_we=1, bram_addr=index, bram_wdata=the result.
- index then increments.
- Otherwise bram_we=0, and bram_addr and bram_wdata hold their values.
REQ-024 Back-to-back acceptances SHALL produce one write per cycle with no bubbles.
REQ-025 Frame end:
- Acceptance of the sample at index DEPTH-1 SHALL move the FSM to DONE on the same edge, so in_ready=0 in the next cycle.
- That final write still occurs in the first DONE cycle.
- index SHALL NOT wrap within a frame.
REQ-026 DONE SHALL persist with done=1 and sat_count held until start or rst.
REQ-027 in_valid while not in RUN SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force the following:
- state IDLE, index 0, LFSR = SEED;
- in_ready=0, bram_we=0, bram_addr=0, bram_wdata=0;
- busy=0, done=0, sat_count=0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no further write; any pending write is discarded.

Verification
REQ-030 switches=4'b0000, start, then 1024 samples with in_data=i mod 256 and in_valid=1 continuously:
- addr i receives i mod 256 one cycle after acceptance;
- done rises after the 1024th write cycle begins;
- sat_count=0.
REQ-031 switches=4'b1111, start, first sample in_data=200 -> bram_wdata=169 at addr 0 (noise -31 from 8'hE1).
REQ-032 switches=4'b1111, start, first sample in_data=20 -> bram_wdata=0 and sat_count=1.
REQ-033 switches=4'b1011, first sample in_data=100 -> bram_wdata=98 (-31>>>4 = -2).
REQ-034 in_valid toggled randomly, then rst pulsed at index 500 -> next start rewrites from addr 0 with a SEED-based sequence.
- The bench compares all 1024 writes against a reference model.
REQ-035 start in RUN and in_valid in DONE -> no state change, no extra write, index unchanged.
